// File: rtl/ram_bist_sequencer_pkg.sv
// ram_bist_sequencer_pkg: shared state encoding, LFSR constants and next-state helper.
package ram_bist_sequencer_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Taps for x^8+x^6+x^5+x^4+1 in a shift-left Fibonacci register
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam int RD_LAT = 1;
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ^(v & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/ram_bist_sequencer_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR with load; reset value is the shared seed.
module lfsr8
   import ram_bist_sequencer_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_load,
   input  logic [7:0] i_load_value,
   output logic [7:0] o_value
);
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) o_value <= LFSR_SEED;
      else o_value <= i_load ? i_load_value : i_en ? lfsr_next(o_value) : o_value;
endmodule

// File: rtl/ram_bist_sequencer.sv
// ram_bist_sequencer: continuous write/read-back/compare passes over a single-port RAM.
module ram_bist_sequencer
   import ram_bist_sequencer_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start_system,
   input  logic              i_stop_system,
   output logic              o_ram_we,
   output logic              o_ram_re,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_busy,
   output logic              o_mismatch,
   output logic [31:0]       data_sets_generated,
   output logic [31:0]       data_sets_matched
);
   state_t r_state;
   logic r_start, r_stop, r_stop_pending, r_err, r_cmp_valid;
   logic [DATA_W-1:0] r_exp, w_gen, w_replay;
   logic w_go, w_stop, w_last, w_seed_load, w_wr_issue, w_rd_issue, w_miss;
   assign w_go = r_state == S_IDLE && r_start && !r_stop;
   assign w_stop = r_stop_pending || r_stop;
   assign w_last = &o_ram_addr;
   assign w_seed_load = w_go || (r_state == S_DRAIN && !w_stop);
   assign w_wr_issue = w_seed_load || (r_state == S_WRITE && !w_last);
   assign w_rd_issue = r_state == S_WRITE ? w_last : r_state == S_READ && !w_last;
   assign w_miss = r_cmp_valid && i_ram_rdata != r_exp;
   assign o_busy = r_state != S_IDLE;
   lfsr8 u_gen (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(w_wr_issue), .i_load(1'b0),
      .i_load_value(8'h00), .o_value(w_gen)
   );
   // Replay holds the set's seed through WRITE, then steps alongside the reads
   lfsr8 u_replay (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(o_ram_re), .i_load(w_seed_load),
      .i_load_value(w_gen), .o_value(w_replay)
   );
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_state <= S_IDLE;
         r_start <= 1'b0;
         r_stop <= 1'b0;
         r_stop_pending <= 1'b0;
         r_err <= 1'b0;
         r_cmp_valid <= 1'b0;
         r_exp <= '0;
         o_ram_we <= 1'b0;
         o_ram_re <= 1'b0;
         o_ram_addr <= '0;
         o_ram_wdata <= '0;
         o_mismatch <= 1'b0;
         data_sets_generated <= '0;
         data_sets_matched <= '0;
      end else begin
         r_start <= i_start_system;
         r_stop <= i_stop_system;
         o_ram_we <= w_wr_issue;
         o_ram_re <= w_rd_issue;
         o_ram_addr <= (r_state == S_WRITE || r_state == S_READ) ? o_ram_addr + 1'b1 : '0;
         o_ram_wdata <= w_wr_issue ? w_gen : '0;
         r_exp <= w_replay;
         r_cmp_valid <= o_ram_re;
         o_mismatch <= w_miss;
         r_err <= r_state != S_DRAIN && (r_err || w_miss);
         r_stop_pending <= r_state != S_DRAIN && (r_stop_pending || (r_stop && r_state != S_IDLE));
         if (r_state == S_WRITE && w_last) data_sets_generated <= data_sets_generated + 32'd1;
         if (r_state == S_DRAIN && !r_err && !w_miss) data_sets_matched <= data_sets_matched + 32'd1;
         case (r_state)
            S_IDLE:  if (w_go) r_state <= S_WRITE;
            S_WRITE: if (w_last) r_state <= S_READ;
            S_READ:  if (w_last) r_state <= S_DRAIN;
            default: r_state <= w_stop ? S_IDLE : S_WRITE;
         endcase
      end
endmodule
